vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 100 MHz board clock.
- Drives the pixel coordinate bus (o_x, o_y) consumed by the image generator, plus HSYNC/VSYNC to the connector.
- Provides active-video, pixel-enable and frame-start strobes.
- Sync outputs pass through a configurable delay so they stay aligned with downstream registered RGB.

Parameters:
- CLK_DIV, 4, i_clk cycles per pixel (100 MHz / 4 = 25 MHz pixel rate)
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_DELAY, 1, pixel periods of delay applied to o_hsync/o_vsync (0..4)

Ports:
- i_clk  input  1  system clock, 100 MHz
- i_rst  input  1  synchronous active-high reset
- o_x  output  11  horizontal coordinate, 1..H_ACTIVE in active video, 0 in blanking
- o_y  output  10  vertical coordinate, 1..V_ACTIVE in active lines, 0 in blanking lines
- o_active  output  1  high when both o_x and o_y are nonzero
- o_pix_en  output  1  one-i_clk pulse per pixel period
- o_frame_start  output  1  one-i_clk pulse at the start of each frame
- o_hsync  output  1  horizontal sync, active low
- o_vsync  output  1  vertical sync, active low

Behaviour:
- One clock domain (i_clk). Reset is synchronous, active-high, and dominates all other logic.
- Derived constants: H_TOTAL = sum of H_* = 800; V_TOTAL = sum of V_* = 525.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - Internal tick = (div_cnt == CLK_DIV-1).
  - o_pix_en is the registered tick, so it rises 1 i_clk after the tick cycle.
  - Period is exactly CLK_DIV i_clk.
- Counters:
  - h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1) advance only on tick.
  - h_cnt wraps H_TOTAL-1 -> 0; v_cnt increments only on that wrap.
  - v_cnt wraps V_TOTAL-1 -> 0 only when both counters are at maximum simultaneously.
- Coordinate decode, registered every i_clk from the current counters:
  - o_x = h_cnt+1 if h_cnt < H_ACTIVE, else 0.
  - o_y = v_cnt+1 if v_cnt < V_ACTIVE, else 0.
  - o_active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - o_x, o_y and o_active hold constant for the whole pixel period and change together one i_clk after the counter update.
- Sync decode, raw signals:
  - hs_raw low when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw low when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
- Sync delay:
  - Raw syncs enter a SYNC_DELAY-deep shift register that advances only on tick.
  - The output stage is registered on i_clk.
  - SYNC_DELAY=0 means syncs are aligned with o_x/o_y.
- o_frame_start: one-i_clk pulse, registered, asserted when the tick moves the counters from (H_TOTAL-1, V_TOTAL-1) to (0,0), coincident with o_pix_en.
- Reset values:
  - div_cnt, h_cnt and v_cnt = 0.
  - o_x = 0, o_y = 0, o_active = 0, o_pix_en = 0, o_frame_start = 0.
  - o_hsync = 1, o_vsync = 1; sync delay stages = 1.
  - First cycle after reset release: o_x=1, o_y=1, o_active=1.
  - The first frame after reset produces no o_frame_start; the first pulse marks the end of frame 0.
- Reset mid-line or mid-frame:
  - Counters return to 0 next cycle with no partial-pulse completion.
  - Syncs go inactive immediately.
- Synthesis must fail if SYNC_DELAY exceeds 4 or CLK_DIV is less than 2.

Test Plan:
- Reset held 5 cycles, then released -> during reset o_hsync=o_vsync=1, o_x=o_y=0. One cycle after release o_x=1, o_y=1, o_active=1. o_pix_en period is 4 clks.
- Run one line -> o_x steps 1..640, each value held 4 clks. o_x=0 for 160 pixels (640 clks). With SYNC_DELAY=0, o_hsync is low for exactly 384 clks starting at h_cnt=656. Line period is 3200 clks.
- Run one full frame -> o_y steps 1..480, then 0 for 45 lines. o_vsync is low for exactly 2 lines (6400 clks) starting at line 490. o_frame_start pulses every 1,680,000 clks.
- SYNC_DELAY=1 vs 0 -> the o_hsync falling edge lags by exactly 4 clks (1 pixel). o_x/o_y timing is unchanged.
- Assert i_rst for 1 clk mid-frame at h_cnt=700 (inside hsync), v_cnt=491 (inside vsync) -> next cycle o_hsync=o_vsync=1. Two cycles later o_x=1, o_y=1. No o_frame_start pulse.
- Check o_active over a full frame -> high for exactly 307,200 pixels. o_active is never high when o_x=0 or o_y=0.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Pixel coordinate, strobe and sync bundle between the VGA timing generator
// and its consumers (image generator, connector pins).
interface vga_timing_gen_if;
   logic [10:0] o_x;
   logic [9:0]  o_y;
   logic        o_active;
   logic        o_pix_en;
   logic        o_frame_start;
   logic        o_hsync;
   logic        o_vsync;

   modport master (
      output o_x, o_y, o_active, o_pix_en, o_frame_start, o_hsync, o_vsync
   );

   modport slave (
      input o_x, o_y, o_active, o_pix_en, o_frame_start, o_hsync, o_vsync
   );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel divider, h/v counters, registered
// coordinate decode and tick-clocked sync delay line.
module vga_timing_gen #(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned H_FP       = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BP       = 48,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned V_FP       = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BP       = 33,
   parameter int unsigned SYNC_DELAY = 1
) (
   input logic         i_clk,
   input logic         i_rst,
   vga_timing_gen_if.master vga
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned H_W     = $clog2(H_TOTAL);
   localparam int unsigned V_W     = $clog2(V_TOTAL);
   localparam int unsigned SR_W    = (SYNC_DELAY == 0) ? 1 : SYNC_DELAY;
   localparam int unsigned X_W     = 11;
   localparam int unsigned Y_W     = 10;

   generate
      if (SYNC_DELAY > 4 || CLK_DIV < 2) begin : g_param_check
         $error("vga_timing_gen: SYNC_DELAY must be 0..4 and CLK_DIV must be >= 2");
      end
   endgenerate

   logic [DIV_W-1:0] div_q, div_d;
   logic [H_W-1:0]   h_q, h_d;
   logic [V_W-1:0]   v_q, v_d;
   logic [SR_W-1:0]  hs_sr_q, hs_sr_d;
   logic [SR_W-1:0]  vs_sr_q, vs_sr_d;
   logic [X_W-1:0]   x_q, x_d;
   logic [Y_W-1:0]   y_q, y_d;
   logic             active_q, active_d;
   logic             pix_en_q, pix_en_d;
   logic             fs_q, fs_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;

   logic tick_c, h_last_c, v_last_c, h_act_c, v_act_c, hs_raw_c, vs_raw_c;

   assign tick_c   = (div_q == DIV_W'(CLK_DIV - 1));
   assign h_last_c = (h_q == H_W'(H_TOTAL - 1));
   assign v_last_c = (v_q == V_W'(V_TOTAL - 1));
   assign h_act_c  = (h_q < H_W'(H_ACTIVE));
   assign v_act_c  = (v_q < V_W'(V_ACTIVE));
   assign hs_raw_c = !((h_q >= H_W'(H_ACTIVE + H_FP)) &&
                       (h_q <  H_W'(H_ACTIVE + H_FP + H_SYNC)));
   assign vs_raw_c = !((v_q >= V_W'(V_ACTIVE + V_FP)) &&
                       (v_q <  V_W'(V_ACTIVE + V_FP + V_SYNC)));

   // Next-state: counters and sync delay line advance only on the pixel tick
   always_comb begin
      div_d   = div_q + DIV_W'(1);
      h_d     = h_q;
      v_d     = v_q;
      hs_sr_d = hs_sr_q;
      vs_sr_d = vs_sr_q;
      if (tick_c) begin
         div_d = '0;
         if (h_last_c) begin
            h_d = '0;
            v_d = v_last_c ? '0 : v_q + V_W'(1);
         end else begin
            h_d = h_q + H_W'(1);
         end
         hs_sr_d = SR_W'({hs_sr_q, hs_raw_c});
         vs_sr_d = SR_W'({vs_sr_q, vs_raw_c});
      end

      x_d      = h_act_c ? X_W'(h_q) + X_W'(1) : '0;
      y_d      = v_act_c ? Y_W'(v_q) + Y_W'(1) : '0;
      active_d = h_act_c && v_act_c;
      pix_en_d = tick_c;
      fs_d     = tick_c && h_last_c && v_last_c;
      // Oldest delay stage feeds the pins; zero delay bypasses the line entirely
      hsync_d  = (SYNC_DELAY == 0) ? hs_raw_c : hs_sr_q[SR_W-1];
      vsync_d  = (SYNC_DELAY == 0) ? vs_raw_c : vs_sr_q[SR_W-1];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         div_q    <= '0;
         h_q      <= '0;
         v_q      <= '0;
         hs_sr_q  <= '1;
         vs_sr_q  <= '1;
         x_q      <= '0;
         y_q      <= '0;
         active_q <= 1'b0;
         pix_en_q <= 1'b0;
         fs_q     <= 1'b0;
         hsync_q  <= 1'b1;
         vsync_q  <= 1'b1;
      end else begin
         div_q    <= div_d;
         h_q      <= h_d;
         v_q      <= v_d;
         hs_sr_q  <= hs_sr_d;
         vs_sr_q  <= vs_sr_d;
         x_q      <= x_d;
         y_q      <= y_d;
         active_q <= active_d;
         pix_en_q <= pix_en_d;
         fs_q     <= fs_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
      end
   end

   assign vga.o_x           = x_q;
   assign vga.o_y           = y_q;
   assign vga.o_active      = active_q;
   assign vga.o_pix_en      = pix_en_q;
   assign vga.o_frame_start = fs_q;
   assign vga.o_hsync       = hsync_q;
   assign vga.o_vsync       = vsync_q;

endmodule
